display_mux: RTL

Time-multiplexing controller that drives a two-digit common-anode seven-segment display through the single `seven_seg_display` hex decoder. It sits directly upstream of that decoder: it samples two 4-bit hex values, presents one of them on the decoder input `s`, and drives the matching active-low digit-enable lines. It also outputs the registered 5-bit sum of the two values for the board LEDs. A fixed refresh period and an optional inter-digit dead time suppress ghosting.

---
 rtl/display_mux.sv | 98 +++++++++
 1 files changed

// File: rtl/display_mux.sv
// display_mux: time-multiplexes two hex digits onto one seven-segment decoder
// Ports: clk; reset (async, active-low); s0/s1 hex values for digit 0 (right) and
// digit 1 (left); s value to the decoder; an active-low digit enables
// (an[0] = digit 0); sum = s0 + s1 captured at the start of each frame.
// Macro DISPLAY_MUX_BLANK_EN inserts BLANK_CYCLES of dead time (both digits off)
// after each digit; when it is undefined the digits alternate directly.
module display_mux #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] s,
  output logic [1:0] an,
  output logic [4:0] sum
);
  localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] DW = CW'(DWELL_CYCLES - 1);
`ifdef DISPLAY_MUX_BLANK_EN
  localparam logic [CW-1:0] BW = CW'(BLANK_CYCLES - 1);
`endif
  typedef enum logic [2:0] {IDLE, SHOW0, BLANK0, SHOW1, BLANK1} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    h1_q;
  logic [3:0]    s_q;
  logic [1:0]    an_q;
  logic [4:0]    sum_q;
  logic [4:0]    sum_d;
  logic          done;
  logic          cap;
  assign sum_d = {1'b0, s0} + {1'b0, s1};
  assign done  = cnt_q == '0;
  // A frame starts when leaving reset or when the last state of the frame expires.
`ifdef DISPLAY_MUX_BLANK_EN
  assign cap = state_q == IDLE || (state_q == BLANK1 && done);
`else
  assign cap = state_q == IDLE || (state_q == SHOW1 && done);
`endif
  // s_q doubles as the digit-0 holding register: it is loaded with s0 at capture
  // and nothing else writes it until digit 1 is shown.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h1_q    <= '0;
      s_q     <= '0;
      an_q    <= 2'b11;
      sum_q   <= '0;
    end else if (cap) begin
      state_q <= SHOW0;
      cnt_q   <= DW;
      h1_q    <= s1;
      s_q     <= s0;
      an_q    <= 2'b10;
      sum_q   <= sum_d;
    end else if (!done) begin
      cnt_q <= cnt_q - CW'(1);
    end else begin
      case (state_q)
`ifdef DISPLAY_MUX_BLANK_EN
        SHOW0: begin
          state_q <= BLANK0;
          cnt_q   <= BW;
          an_q    <= 2'b11;
        end
        BLANK0: begin
          state_q <= SHOW1;
          cnt_q   <= DW;
          an_q    <= 2'b01;
          s_q     <= h1_q;
        end
        SHOW1: begin
          state_q <= BLANK1;
          cnt_q   <= BW;
          an_q    <= 2'b11;
        end
`else
        SHOW0: begin
          state_q <= SHOW1;
          cnt_q   <= DW;
          an_q    <= 2'b01;
          s_q     <= h1_q;
        end
`endif
        default: begin
          state_q <= IDLE;
          an_q    <= 2'b11;
        end
      endcase
    end
  assign s   = s_q;
  assign an  = an_q;
  assign sum = sum_q;
endmodule
